// File: rtl/clkgen_nco_multi.sv
// ---------------------------------------------------------------------------
// clkgen_nco_multi
//
// Register-programmable multi-channel clock generator built from numerically
// controlled oscillators. Each channel owns a phase accumulator that advances
// by INC every system clock. The accumulator MSB is the channel's square-wave
// clock enable, and its carry-out is a one-cycle tick strobe.
// f_out = f_clk * INC / 2^ACC_W.
// A small lock FSM reports when the configuration has been stable for
// LOCK_CYCLES clocks with at least one channel enabled.
//
// Optional feature macro: CLKGEN_SAFE_STOP_EN
//   When defined, disabling a channel while its clk_out is high lets the high
//   phase finish before the channel parks. This avoids truncated pulses.
//   Per-channel "stopping" flags appear in STATUS[NUM_CH+7:8].
//   When undefined, disable is immediate and STATUS[15:8] reads 0.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   avs_address    register word address
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_read       read strobe
//   avs_readdata   registered read data, valid the cycle after avs_read
//   clk_out        per-channel square wave (accumulator MSB, gated by EN)
//   tick           per-channel one-cycle pulse on accumulator carry-out
//   locked         configuration stable and at least one channel enabled
//
// Register map (word addresses):
//   0         CTRL   [NUM_CH-1:0] EN, [31] RESYNC (write-only, reads 0)
//   1         STATUS [0] locked, [2:1] FSM state, [NUM_CH+7:8] stopping
//   2+2*ch    INC[ch]
//   3+2*ch    PHASE[ch]
// ---------------------------------------------------------------------------
module clkgen_nco_multi #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int CNT_W   = $clog2(LOCK_CYCLES);
  localparam int CFG_END = 2 + 2 * NUM_CH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [ACC_W-1:0]  inc_q   [NUM_CH];
  logic [ACC_W-1:0]  inc_d   [NUM_CH];
  logic [ACC_W-1:0]  phase_q [NUM_CH];
  logic [ACC_W-1:0]  phase_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q   [NUM_CH];
  logic [ACC_W-1:0]  acc_d   [NUM_CH];
  logic [ACC_W:0]    sum_w   [NUM_CH];
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
`ifdef CLKGEN_SAFE_STOP_EN
  logic [NUM_CH-1:0] stop_q, stop_d;
`endif
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [31:0]       rdata_q, rdata_d, rdata_sel;

  logic ctrl_wr;
  logic resync;
  logic cfg_wr;

  // Bus decode. Only CTRL and the INC/PHASE block count as configuration
  // writes. STATUS and unmapped addresses leave the lock FSM untouched.
  always_comb begin
    ctrl_wr = avs_write && (avs_address == 4'd0);
    resync  = ctrl_wr && avs_writedata[31];
    cfg_wr  = ctrl_wr ||
              (avs_write && ({1'b0, avs_address} >= 5'd2) &&
               ({1'b0, avs_address} < 5'(CFG_END)));
  end

  // Register file update. Write bits at or above ACC_W are dropped.
  always_comb begin
    en_d = en_q;
    if (ctrl_wr) en_d = avs_writedata[NUM_CH-1:0];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      inc_d[ch]   = inc_q[ch];
      phase_d[ch] = phase_q[ch];
      if (avs_write && (avs_address == 4'(2 + 2 * ch)))
        inc_d[ch] = avs_writedata[ACC_W-1:0];
      if (avs_write && (avs_address == 4'(3 + 2 * ch)))
        phase_d[ch] = avs_writedata[ACC_W-1:0];
    end
  end

  // Channel datapath. It uses the EN and INC values already in effect, so a
  // write only changes behaviour from the following cycle. RESYNC beats
  // accumulation and reloads every accumulator from its PHASE register.
  // A disabled channel keeps its accumulator parked at PHASE. This is why
  // PHASE writes take effect only on disable or RESYNC.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum_w[ch]     = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};
      acc_d[ch]     = phase_q[ch];
      tick_d[ch]    = 1'b0;
      clk_out_d[ch] = 1'b0;
`ifdef CLKGEN_SAFE_STOP_EN
      stop_d[ch]    = stop_q[ch];
`endif
      if (resync) begin
        acc_d[ch]     = phase_q[ch];
        clk_out_d[ch] = en_q[ch] & phase_q[ch][ACC_W-1];
`ifdef CLKGEN_SAFE_STOP_EN
        stop_d[ch]    = 1'b0;
`endif
      end else if (en_q[ch]) begin
        acc_d[ch]     = sum_w[ch][ACC_W-1:0];
        tick_d[ch]    = sum_w[ch][ACC_W];
        clk_out_d[ch] = sum_w[ch][ACC_W-1];
      end
`ifdef CLKGEN_SAFE_STOP_EN
      // A stopping channel runs on until the MSB would fall. On that edge it
      // parks at PHASE with clk_out low, so the last high pulse is full width.
      else if (stop_q[ch]) begin
        if (sum_w[ch][ACC_W-1]) begin
          acc_d[ch]     = sum_w[ch][ACC_W-1:0];
          tick_d[ch]    = sum_w[ch][ACC_W];
          clk_out_d[ch] = 1'b1;
        end else begin
          stop_d[ch]    = 1'b0;
        end
      end
      if (ctrl_wr) begin
        if (avs_writedata[ch])
          stop_d[ch] = 1'b0;
        else if (en_q[ch] && clk_out_d[ch])
          stop_d[ch] = 1'b1;
      end
`endif
    end
  end

  // Lock FSM. Every configuration write restarts the settle count, or goes
  // to IDLE when the write leaves all channels disabled. A write landing on
  // the terminal count therefore wins over the LOCKED transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_wr) begin
      cnt_d   = '0;
      state_d = (en_d != '0) ? SETTLE : IDLE;
    end else begin
      case (state_q)
        IDLE:   ;
        SETTLE: begin
          if (cnt_q == CNT_W'(LOCK_CYCLES - 1))
            state_d = LOCKED;
          else
            cnt_d = cnt_q + 1'b1;
        end
        LOCKED: ;
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // Read mux. The data is captured only on a read strobe, so it holds until
  // the next read.
  always_comb begin
    rdata_sel = '0;
    if (avs_address == 4'd0) begin
      rdata_sel[NUM_CH-1:0] = en_q;
    end else if (avs_address == 4'd1) begin
      rdata_sel[0]   = locked_q;
      rdata_sel[2:1] = state_q;
`ifdef CLKGEN_SAFE_STOP_EN
      rdata_sel[NUM_CH+7:8] = stop_q;
`endif
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (avs_address == 4'(2 + 2 * ch)) rdata_sel = 32'(inc_q[ch]);
      if (avs_address == 4'(3 + 2 * ch)) rdata_sel = 32'(phase_q[ch]);
    end
    rdata_d = avs_read ? rdata_sel : rdata_q;
  end

  // State registers. Reset clears everything on the next edge, even in the
  // middle of operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q      <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
`ifdef CLKGEN_SAFE_STOP_EN
      stop_q    <= '0;
`endif
      state_q   <= IDLE;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      rdata_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        inc_q[ch]   <= '0;
        phase_q[ch] <= '0;
        acc_q[ch]   <= '0;
      end
    end else begin
      en_q      <= en_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
`ifdef CLKGEN_SAFE_STOP_EN
      stop_q    <= stop_d;
`endif
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      rdata_q   <= rdata_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        inc_q[ch]   <= inc_d[ch];
        phase_q[ch] <= phase_d[ch];
        acc_q[ch]   <= acc_d[ch];
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign clk_out      = clk_out_q;
  assign tick         = tick_q;
  assign locked       = locked_q;

endmodule
